// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants and types for the CPU/DMA memory arbiter
package cpu_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  localparam logic [1:0] ARB_ST_CPU = 2'b00;
  localparam logic [1:0] ARB_ST_DMA = 2'b01;
  localparam logic [1:0] ARB_ST_GAP = 2'b10;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [1:0] {
    S_CPU = ARB_ST_CPU,
    S_DMA = ARB_ST_DMA,
    S_GAP = ARB_ST_GAP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - CPU, DMA and memory signals of the arbiter; cpu_lock exists only with MEM_ARB_LOCK_EN
interface mem_arbiter_if;
  import cpu_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_rdy;
`ifdef MEM_ARB_LOCK_EN
  logic              cpu_lock;
`endif
  logic              dma_req;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_we;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;
  logic              dma_active;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_addr, cpu_wdata, cpu_we,
`ifdef MEM_ARB_LOCK_EN
    output cpu_lock,
`endif
    output dma_req, dma_addr, dma_wdata, dma_we, mem_rdata,
    input  cpu_rdy, dma_gnt, dma_rdata, dma_rvalid, dma_active,
    input  mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  cpu_req, cpu_addr, cpu_wdata, cpu_we,
`ifdef MEM_ARB_LOCK_EN
    input  cpu_lock,
`endif
    input  dma_req, dma_addr, dma_wdata, dma_we, mem_rdata,
    output cpu_rdy, dma_gnt, dma_rdata, dma_rvalid, dma_active,
    output mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - cycle-stealing CPU/DMA arbiter for a single-port memory
// Optional MEM_ARB_LOCK_EN adds cpu_lock, which holds off new DMA bursts.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int BURST_MAX  = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic           CLK,
  input logic           R,
  mem_arbiter_if.slave  bus
);

  localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

  arb_state_t        state;
  logic [3:0]        cnt;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              lock;
  logic              owner;

`ifdef MEM_ARB_LOCK_EN
  assign lock = bus.cpu_lock;
`else
  assign lock = 1'b0;
`endif

  // Owner is gated by R so every bus output falls back to the CPU side during reset.
  assign owner = (R && state == S_DMA && bus.dma_req) ? OWN_DMA : OWN_CPU;

  assign bus.dma_gnt    = (owner == OWN_DMA);
  assign bus.cpu_rdy    = R && (owner == OWN_CPU) && bus.cpu_req;
  assign bus.dma_active = R && (state == S_DMA);
  assign bus.mem_addr   = (owner == OWN_DMA) ? bus.dma_addr  : bus.cpu_addr;
  assign bus.mem_wdata  = (owner == OWN_DMA) ? bus.dma_wdata : bus.cpu_wdata;
  assign bus.mem_we     = R && ((owner == OWN_DMA) ? bus.dma_we : (bus.cpu_req && bus.cpu_we));
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_rvalid = rvalid_q;

  // cnt counts burst grants in S_DMA and forced CPU cycles in S_GAP.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state    <= S_CPU;
      cnt      <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (owner == OWN_DMA && !bus.dma_we) begin
        rdata_q  <= bus.mem_rdata;
        rvalid_q <= 1'b1;
      end
      case (state)
        S_CPU: begin
          if (bus.dma_req && !lock) begin
            state <= S_DMA;
            cnt   <= '0;
          end
        end
        S_DMA: begin
          if (!bus.dma_req) begin
            state <= S_CPU;
          end else if (cnt == BURST_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= (bus.dma_req && !lock) ? S_DMA : S_CPU;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= S_CPU;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
